pzcorebus_request_arbiter: RTL and testbench
============================================

// Module: pzcorebus_request_arbiter
// PURPOSE
// - Shares one corebus request port (command + request data) between N requesters.
// - Round-robin command arbitration; grant is locked from command-valid until command accept.
// - After a data-carrying command (cmd[2]=1: WRITE/FULL_WRITE/BROADCAST/ATOMIC, posted or NP),
//   the request-data path stays locked to that requester until its last data beat is accepted.
// - Sits between master-side corebus agents and a single slave/interconnect port.
// PARAMETERS
// - N          4    number of requesters, 2..16
// - ID_W       20   command id width
// - ADDR_W     64   address width
// - LEN_W      10   length width
// - DATA_W     256  data width; byte enable width is DATA_W/8
// PORTS
// - i_clk           in   1             clock
// - i_rst_n         in   1             asynchronous active-low reset
// - i_cmd_valid     in   N             per-requester command valid
// - o_cmd_ready     out  N             per-requester command ready
// - i_cmd_type      in   N*4           command type (corebus encoding), requester k at [4k+:4]
// - i_cmd_id        in   N*ID_W        command id
// - i_cmd_addr      in   N*ADDR_W      command address
// - i_cmd_len       in   N*LEN_W       burst length
// - i_data_valid    in   N             request data valid
// - o_data_ready    out  N             request data ready
// - i_data          in   N*DATA_W      request data
// - i_data_be       in   N*DATA_W/8    byte enable
// - i_data_last     in   N             last data beat
// - o_cmd_valid/i_cmd_ready, o_cmd_type/id/addr/len   downstream command, same widths as one slot
// - o_cmd_source    out  $clog2(N)     index of requester owning o_cmd_valid
// - o_data_valid/i_data_ready, o_data/o_data_be/o_data_last   downstream request data
// BEHAVIOUR
// - Reset: state=ARB, rr pointer=0, grant=0, data owner invalid; o_cmd_valid=0, o_data_valid=0,
//   all o_cmd_ready/o_data_ready=0, payload outputs 0. Reset mid-burst abandons the burst.
// - Zero latency: outputs are a mux of the selected requester's inputs; no payload registers.
// - ARB: select first valid requester at or after rr pointer (wrap N-1 -> 0). If any valid,
//   drive o_cmd_valid=1. If i_cmd_ready same cycle: accept, rr pointer = sel+1 mod N.
//   Not accepted -> latch sel into grant, go CMD_HOLD.
// - CMD_HOLD: mux fixed to grant; new valids ignored; stay until i_cmd_ready, then accept.
// - On accept of a no-data command (READ, MESSAGE*, NULL): back to ARB next cycle.
// - On accept of a data command: data owner = grant; go DATA unless last beat accepted in the
//   same cycle (data may accompany its command; owner's data is routed from the accept cycle).
// - Data may also lead its command: requester holding the command grant may push data while in
//   ARB/CMD_HOLD only if it is the selected requester; others see o_data_ready=0.
// - DATA: o_data_* = owner inputs; o_data_ready[owner]=i_data_ready, others 0; no command is
//   granted (o_cmd_valid=0). On beat with i_data_last: ARB next cycle.
// - o_cmd_ready[k]=i_cmd_ready only for k=selected/granted and only in ARB/CMD_HOLD.
// - Arbiter never drops or reorders beats of one requester; data order equals command order.
// - Single-valid case: grant every cycle to that requester, no bubbles for no-data commands.
// TESTING
// - 4 reqs all valid READ, i_cmd_ready=1 -> o_cmd_source 0,1,2,3,0 on consecutive cycles.
// - req1 WRITE len=4 with data, req2 READ valid -> 4 beats from req1, last at beat 4,
//   then req2 READ; o_cmd_valid=0 during beats 2..4.
// - i_cmd_ready=0 for 3 cycles with req0 valid, req3 rises -> source stays 0, payload stable.
// - Data beat with last accepted in same cycle as WRITE len=1 -> ARB next cycle, no bubble.
// - Assert i_rst_n=0 mid DATA burst -> all valids/readys 0 async; after release rr pointer=0.
// - req2 drives data valid while req0 owns bus -> o_data_ready[2]=0, req2 data never forwarded.

Source files
------------

// File: rtl/pzcorebus_request_arbiter.sv
// Round-robin arbiter that shares one corebus request port (command + request data)
// between N requesters. Zero latency: every output is a mux of one requester's inputs.
module pzcorebus_request_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned ID_W   = 20,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned LEN_W  = 10,
   parameter int unsigned DATA_W = 256,
   localparam int unsigned SRC_W = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned BE_W  = DATA_W / 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N-1:0]          i_cmd_valid,
   output logic [N-1:0]          o_cmd_ready,
   input  logic [N*4-1:0]        i_cmd_type,
   input  logic [N*ID_W-1:0]     i_cmd_id,
   input  logic [N*ADDR_W-1:0]   i_cmd_addr,
   input  logic [N*LEN_W-1:0]    i_cmd_len,
   input  logic [N-1:0]          i_data_valid,
   output logic [N-1:0]          o_data_ready,
   input  logic [N*DATA_W-1:0]   i_data,
   input  logic [N*BE_W-1:0]     i_data_be,
   input  logic [N-1:0]          i_data_last,
   output logic                  o_cmd_valid,
   input  logic                  i_cmd_ready,
   output logic [3:0]            o_cmd_type,
   output logic [ID_W-1:0]       o_cmd_id,
   output logic [ADDR_W-1:0]     o_cmd_addr,
   output logic [LEN_W-1:0]      o_cmd_len,
   output logic [SRC_W-1:0]      o_cmd_source,
   output logic                  o_data_valid,
   input  logic                  i_data_ready,
   output logic [DATA_W-1:0]     o_data,
   output logic [BE_W-1:0]       o_data_be,
   output logic                  o_data_last
);

   localparam logic [1:0] ST_ARB      = 2'd0;
   localparam logic [1:0] ST_CMD_HOLD = 2'd1;
   localparam logic [1:0] ST_DATA     = 2'd2;

   logic [3:0]        type_a [N];
   logic [ID_W-1:0]   id_a   [N];
   logic [ADDR_W-1:0] addr_a [N];
   logic [LEN_W-1:0]  len_a  [N];
   logic [DATA_W-1:0] data_a [N];
   logic [BE_W-1:0]   be_a   [N];

   logic [1:0]       state_q, state_d;
   logic [SRC_W-1:0] rr_q, rr_d;
   logic [SRC_W-1:0] grant_q, grant_d;
   logic [SRC_W-1:0] owner_q, owner_d;
   logic             data_done_q, data_done_d;

   logic [SRC_W-1:0] arb_sel, cmd_sel, dat_sel, idx_s;
   logic             any_valid, cmd_acc, dat_acc, cmd_has_data;
   int unsigned      idx;

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign type_a[k] = i_cmd_type[k*4 +: 4];
      assign id_a[k]   = i_cmd_id[k*ID_W +: ID_W];
      assign addr_a[k] = i_cmd_addr[k*ADDR_W +: ADDR_W];
      assign len_a[k]  = i_cmd_len[k*LEN_W +: LEN_W];
      assign data_a[k] = i_data[k*DATA_W +: DATA_W];
      assign be_a[k]   = i_data_be[k*BE_W +: BE_W];
   end

   // First valid requester at or after the round-robin pointer.
   always_comb begin
      arb_sel   = '0;
      any_valid = 1'b0;
      idx       = 0;
      idx_s     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx   = (32'(rr_q) + i) % N;
         idx_s = SRC_W'(idx);
         if (!any_valid && i_cmd_valid[idx_s]) begin
            any_valid = 1'b1;
            arb_sel   = idx_s;
         end
      end
   end

   assign cmd_sel      = (state_q == ST_CMD_HOLD) ? grant_q : arb_sel;
   assign cmd_has_data = type_a[cmd_sel][2];

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      data_done_d  = data_done_q;
      o_cmd_valid  = 1'b0;
      o_cmd_ready  = '0;
      o_data_valid = 1'b0;
      o_data_ready = '0;
      dat_sel      = cmd_sel;
      cmd_acc      = 1'b0;
      dat_acc      = 1'b0;
      case (state_q)
         ST_ARB, ST_CMD_HOLD: begin
            o_cmd_valid = (state_q == ST_ARB) ? any_valid : i_cmd_valid[grant_q];
            if (o_cmd_valid) begin
               o_cmd_ready[cmd_sel] = i_cmd_ready;
            end
            // Data may lead or accompany its command, but only from the selected requester.
            if (o_cmd_valid && cmd_has_data && !data_done_q) begin
               o_data_valid          = i_data_valid[cmd_sel];
               o_data_ready[cmd_sel] = i_data_ready;
            end
            cmd_acc = o_cmd_valid & i_cmd_ready;
            dat_acc = o_data_valid & i_data_ready;
            if (cmd_acc) begin
               rr_d        = (cmd_sel == SRC_W'(N - 1)) ? '0 : cmd_sel + SRC_W'(1);
               grant_d     = cmd_sel;
               owner_d     = cmd_sel;
               data_done_d = 1'b0;
               if (cmd_has_data && !data_done_q && !(dat_acc && i_data_last[cmd_sel])) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_ARB;
               end
            end else if (o_cmd_valid) begin
               grant_d = cmd_sel;
               state_d = ST_CMD_HOLD;
               if (dat_acc && i_data_last[cmd_sel]) begin
                  data_done_d = 1'b1;
               end
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_DATA: begin
            dat_sel               = owner_q;
            o_data_valid          = i_data_valid[owner_q];
            o_data_ready[owner_q] = i_data_ready;
            if (o_data_valid && i_data_ready && i_data_last[owner_q]) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
      // Handshakes are forced low for the whole time reset is asserted.
      if (!i_rst_n) begin
         o_cmd_valid  = 1'b0;
         o_cmd_ready  = '0;
         o_data_valid = 1'b0;
         o_data_ready = '0;
      end
   end

   assign o_cmd_type   = i_rst_n ? type_a[cmd_sel] : '0;
   assign o_cmd_id     = i_rst_n ? id_a[cmd_sel]   : '0;
   assign o_cmd_addr   = i_rst_n ? addr_a[cmd_sel] : '0;
   assign o_cmd_len    = i_rst_n ? len_a[cmd_sel]  : '0;
   assign o_cmd_source = i_rst_n ? cmd_sel         : '0;
   assign o_data       = i_rst_n ? data_a[dat_sel] : '0;
   assign o_data_be    = i_rst_n ? be_a[dat_sel]   : '0;
   assign o_data_last  = i_rst_n & i_data_last[dat_sel];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_ARB;
         rr_q        <= '0;
         grant_q     <= '0;
         owner_q     <= '0;
         data_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         data_done_q <= data_done_d;
      end
   end

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
// Directed bench for pzcorebus_request_arbiter: round-robin order, data locking,
// command hold, same-cycle last beat, and asynchronous reset mid-burst.
module tb_pzcorebus_request_arbiter;

   localparam int unsigned N      = 4;
   localparam int unsigned ID_W   = 20;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned LEN_W  = 10;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam logic [3:0]  RD     = 4'b0001;
   localparam logic [3:0]  WR     = 4'b0100;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        i_cmd_valid, o_cmd_ready;
   logic [N*4-1:0]      i_cmd_type;
   logic [N*ID_W-1:0]   i_cmd_id;
   logic [N*ADDR_W-1:0] i_cmd_addr;
   logic [N*LEN_W-1:0]  i_cmd_len;
   logic [N-1:0]        i_data_valid, o_data_ready, i_data_last;
   logic [N*DATA_W-1:0] i_data;
   logic [N*BE_W-1:0]   i_data_be;
   logic                o_cmd_valid, i_cmd_ready;
   logic [3:0]          o_cmd_type;
   logic [ID_W-1:0]     o_cmd_id;
   logic [ADDR_W-1:0]   o_cmd_addr;
   logic [LEN_W-1:0]    o_cmd_len;
   logic [1:0]          o_cmd_source;
   logic                o_data_valid, i_data_ready, o_data_last;
   logic [DATA_W-1:0]   o_data;
   logic [BE_W-1:0]     o_data_be;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pzcorebus_request_arbiter #(
      .N(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_type(i_cmd_type), .i_cmd_id(i_cmd_id), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
      .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
      .i_data(i_data), .i_data_be(i_data_be), .i_data_last(i_data_last),
      .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
      .o_cmd_type(o_cmd_type), .o_cmd_id(o_cmd_id), .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
      .o_cmd_source(o_cmd_source),
      .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_data(o_data), .o_data_be(o_data_be), .o_data_last(o_data_last)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      i_cmd_valid  = 4'hF;
      i_cmd_type   = {4{RD}};
      i_cmd_id     = '0;
      i_cmd_len    = '0;
      i_cmd_addr   = '0;
      i_data_valid = '0;
      i_data_last  = '0;
      i_data       = '0;
      i_data_be    = '1;
      i_cmd_ready  = 1'b1;
      i_data_ready = 1'b1;
      for (int k = 0; k < N; k++) i_cmd_addr[k*ADDR_W +: ADDR_W] = 64'h1000 + 64'(k);

      // Reset: all handshakes and payload low even with requesters valid
      @(negedge clk); #1;
      chk("rst_cmd_valid", o_cmd_valid, 0);
      chk("rst_cmd_ready", o_cmd_ready, 0);
      chk("rst_cmd_addr", o_cmd_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four READ valid, downstream always ready: source 0,1,2,3,0
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("rr_source", o_cmd_source, c % 4);
         chk("rr_cmd_ready", o_cmd_ready, 4'b0001 << (c % 4));
         chk("rr_cmd_valid", o_cmd_valid, 1);
         @(negedge clk);
      end
      i_cmd_valid = '0;
      #1 chk("idle_cmd_valid", o_cmd_valid, 0);
      @(negedge clk);

      // req1 WRITE len=4 with first beat alongside, req2 READ waiting, req2 pushing stray data
      i_cmd_type[4 +: 4]    = WR;
      i_cmd_len[LEN_W +: LEN_W] = 10'd4;
      i_cmd_valid           = 4'b0110;
      i_data[DATA_W +: DATA_W]   = 256'hA0;
      i_data[2*DATA_W +: DATA_W] = 256'hBAD;
      i_data_valid          = 4'b0110;
      #1;
      chk("wr_source", o_cmd_source, 1);
      chk("wr_beat1_valid", o_data_valid, 1);
      chk("wr_beat1_data", o_data, 256'hA0);
      chk("wr_beat1_ready", o_data_ready, 4'b0010);
      @(negedge clk);
      i_cmd_valid = 4'b0100;
      for (int b = 1; b < 4; b++) begin
         i_data[DATA_W +: DATA_W] = 256'hA0 + 256'(b);
         i_data_last = (b == 3) ? 4'b0010 : 4'b0000;
         #1;
         chk("burst_cmd_valid", o_cmd_valid, 0);
         chk("burst_data", o_data, 256'hA0 + 256'(b));
         chk("burst_data_ready", o_data_ready, 4'b0010);
         chk("burst_last", o_data_last, (b == 3) ? 1 : 0);
         @(negedge clk);
      end
      i_data_valid = 4'b0100;
      i_data_last  = '0;
      #1;
      chk("after_burst_source", o_cmd_source, 2);
      chk("after_burst_cmd_valid", o_cmd_valid, 1);
      chk("read_no_data_valid", o_data_valid, 0);
      chk("read_no_data_ready", o_data_ready, 0);
      @(negedge clk);
      i_cmd_valid  = '0;
      i_data_valid = '0;

      // Downstream stalls with req0 selected; req3 arriving must not steal the grant
      i_cmd_ready = 1'b0;
      i_cmd_valid = 4'b0001;
      #1;
      chk("hold_source0", o_cmd_source, 0);
      chk("hold_cmd_ready0", o_cmd_ready, 0);
      @(negedge clk);
      i_cmd_valid = 4'b1001;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("hold_source", o_cmd_source, 0);
         chk("hold_addr", o_cmd_addr, 64'h1000);
         @(negedge clk);
      end
      i_cmd_ready = 1'b1;
      #1;
      chk("hold_accept_source", o_cmd_source, 0);
      chk("hold_accept_ready", o_cmd_ready, 4'b0001);
      @(negedge clk);

      // req3 WRITE len=1 with its last beat in the same cycle, then req0 READ with no bubble
      i_cmd_type[12 +: 4]        = WR;
      i_cmd_valid                = 4'b1000;
      i_data[3*DATA_W +: DATA_W] = 256'hC3;
      i_data_valid               = 4'b1000;
      i_data_last                = 4'b1000;
      #1;
      chk("wr1_source", o_cmd_source, 3);
      chk("wr1_data", o_data, 256'hC3);
      chk("wr1_last", o_data_last, 1);
      @(negedge clk);
      i_cmd_valid  = 4'b0001;
      i_data_valid = '0;
      i_data_last  = '0;
      #1;
      chk("no_bubble_valid", o_cmd_valid, 1);
      chk("no_bubble_source", o_cmd_source, 0);
      @(negedge clk);

      // Reset asserted while req1 owns a data burst
      i_cmd_valid              = 4'b0010;
      i_data[DATA_W +: DATA_W] = 256'hE1;
      i_data_valid             = 4'b0010;
      #1 chk("rst_burst_source", o_cmd_source, 1);
      @(negedge clk);
      i_cmd_valid = '0;
      #1;
      chk("data_state_cmd_valid", o_cmd_valid, 0);
      chk("data_state_data_valid", o_data_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_data_valid", o_data_valid, 0);
      chk("async_rst_data_ready", o_data_ready, 0);
      chk("async_rst_data", o_data, 0);
      @(negedge clk);
      rst_n        = 1'b1;
      i_data_valid = '0;
      i_cmd_type   = {4{RD}};
      i_cmd_valid  = 4'hF;
      #1;
      chk("post_rst_source", o_cmd_source, 0);
      chk("post_rst_cmd_valid", o_cmd_valid, 1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
